chip_vector_tester: RTL
=======================

Name: chip_vector_tester

Overview:
- Parametrised, table-driven DIP logic-chip tester; successor to the fixed per-chip checkers.
- Steps through an external test-vector ROM, one vector at a time. For each vector it drives the input pins, waits a settle time, samples the output pins through a synchroniser, and compares them against expected values under a care mask.
- Reports pass/fail, the first failing vector index and the mismatching pins.
- Sits between the top-level selection/display FSM and the tri-state pin buffers; one instance replaces all per-chip modules.

Parameters:
- NUM_PINS, 14, number of DUT pins handled (bit i = Pin(i+1)).
- NUM_VEC, 16, maximum vectors per test; VEC_AW = $clog2(NUM_VEC) is derived in the shared package function.
- SETTLE_CYCLES, 4, cycles between driving a vector and sampling; must be >= 2 to cover the synchroniser.
- STOP_ON_FAIL, 1, 1 = end the test at the first mismatch; 0 = run all vectors and record the first mismatch.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous active-high reset
- Start  in  1  one-cycle pulse; begins a test when idle
- vec_count  in  VEC_AW+1  number of vectors to run (0..NUM_VEC)
- dir_mask  in  NUM_PINS  1 = tester drives pin, 0 = tester samples pin; must be held stable while Busy
- vec_addr  out  VEC_AW  ROM address; ROM data is valid one cycle after the address
- vec_drive  in  NUM_PINS  ROM drive values
- vec_expect  in  NUM_PINS  ROM expected values
- vec_care  in  NUM_PINS  ROM compare mask
- pin_out  out  NUM_PINS  values driven to the pin buffers
- pin_oe  out  NUM_PINS  per-pin output enable
- pin_in  in  NUM_PINS  raw pin readback (asynchronous)
- Busy  out  1  test in progress
- Done  out  1  one-cycle pulse when a test ends
- Pass  out  1  result; valid from Done until the next Start
- Fail_idx  out  VEC_AW  index of the first failing vector
- Fail_pins  out  NUM_PINS  mismatch bits of the first failing vector

Behaviour:
- Reset (asynchronous, any state): state = IDLE; pin_oe = 0 (all pins released); pin_out = 0; vec_addr = 0; Busy = 0; Done = 0; Pass = 0; Fail_idx = 0; Fail_pins = 0; settle counter and vector index = 0; synchroniser flops = 0.
- pin_in passes through a 2-flop synchroniser; only the synchronised value is compared.
- FSM states:
  - IDLE: Start -> FETCH. Clear Pass, Fail_idx and Fail_pins; idx = 0; Busy = 1. If vec_count == 0, go straight to DONE with Pass = 1.
  - FETCH (1 cycle): vec_addr = idx.
  - DRIVE (1 cycle): register pin_out <= vec_drive & dir_mask, pin_oe <= dir_mask. Latch vec_expect & vec_care into working registers. Load the settle counter with SETTLE_CYCLES-1.
  - SETTLE (SETTLE_CYCLES cycles): decrement the counter; at 0 -> SAMPLE.
  - SAMPLE (1 cycle): compute mism = (sync_in ^ expect) & care & ~dir_mask.
    - If mism != 0 and no failure has been recorded yet: Fail_idx <= idx, Fail_pins <= mism, set the fail flag.
    - If (mism != 0 and STOP_ON_FAIL), or idx == vec_count-1: go to DONE.
    - Otherwise idx++ and go to FETCH.
  - DONE (1 cycle): Done = 1; Pass = ~fail flag; Busy = 0; pin_oe = 0; go to IDLE.
- Per-vector cost is SETTLE_CYCLES+3 cycles. With Start sampled at cycle 0, the Done pulse occurs at cycle N*(SETTLE_CYCLES+3)+1 when all N vectors run.
- Driven pins are never compared (care is forced off by ~dir_mask), so contention cannot produce false failures.
- pin_out and pin_oe hold the last vector's values between vectors (no glitch to Z) until DONE.
- Start while Busy is ignored. Start coinciding with the DONE cycle is ignored. Start in the cycle after Done starts a new test.
- vec_count > NUM_VEC is clamped to NUM_VEC.
- idx never wraps: termination is checked before increment.
- Reset asserted mid-test aborts immediately. There is no Done pulse, and Pass reads 0 after reset.

Decomposition:
- Package chip_tester_pkg:
  - state enum (IDLE, FETCH, DRIVE, SETTLE, SAMPLE, DONE);
  - the VEC_AW clog2 helper;
  - pin-index constants for VCC/GND (Pin14/Pin7) for the ROM builders.
- One sub-module, pin_sync: a parametrised NUM_PINS-wide 2-flop synchroniser with asynchronous reset.
- The vector ROM is outside this block; per-chip tables (7400, 7402, ...) are ROM init files selected at the top level.

Test Plan:
- 7400 model, 4 vectors (A,B = 00/01/10/11, expect Y = 1,1,1,0 on all gates), SETTLE_CYCLES=4 -> Done at cycle 29; Pass=1, Fail_idx=0, Fail_pins=0; pin_oe equals dir_mask during the test and is 0 after Done.
- Same test, model with Pin3 stuck-at-1, STOP_ON_FAIL=1 -> Done after vector 3 (cycle 29); Pass=0, Fail_idx=3, Fail_pins=14'h0004.
- Pin6 mismatching on vectors 1 and 2, STOP_ON_FAIL=0 -> all 4 vectors run; Fail_idx=1 (first), Fail_pins=14'h0020, Pass=0.
- vec_count=0, Start -> Done at cycle 1, Pass=1, no pin ever enabled.
- Reset pulsed during SETTLE of vector 2 -> next cycle pin_oe=0, Busy=0, no Done pulse. A fresh Start then runs a full test and passes.
- Second Start pulses issued while Busy, including one in the DONE cycle -> ignored: exactly one Done pulse, timing unchanged.

Source files
------------

// File: rtl/chip_vector_tester_pkg.sv
// Shared types and constants for the table-driven DIP chip tester.
package chip_tester_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DRIVE, SETTLE, SAMPLE, DONE} state_e;

  // Vector address width; never narrower than one bit.
  function automatic int unsigned vec_aw(input int unsigned num_vec);
    return (num_vec <= 2) ? 1 : $clog2(num_vec);
  endfunction

  // Supply pin bit positions (Pin7 = GND, Pin14 = VCC) for the ROM builders.
  localparam int unsigned PIN_GND = 6;
  localparam int unsigned PIN_VCC = 13;

endpackage

// File: rtl/chip_vector_tester_if.sv
// Host, vector-ROM and pin-buffer signals of the chip tester.
interface chip_vector_tester_if #(
  parameter int unsigned NUM_PINS = 14,
  parameter int unsigned VEC_AW   = 4
);
  logic                Start;
  logic [VEC_AW:0]     vec_count;
  logic [NUM_PINS-1:0] dir_mask;
  logic [VEC_AW-1:0]   vec_addr;
  logic [NUM_PINS-1:0] vec_drive;
  logic [NUM_PINS-1:0] vec_expect;
  logic [NUM_PINS-1:0] vec_care;
  logic [NUM_PINS-1:0] pin_out;
  logic [NUM_PINS-1:0] pin_oe;
  logic [NUM_PINS-1:0] pin_in;
  logic                Busy;
  logic                Done;
  logic                Pass;
  logic [VEC_AW-1:0]   Fail_idx;
  logic [NUM_PINS-1:0] Fail_pins;

  modport slave (
    input  Start, vec_count, dir_mask, vec_drive, vec_expect, vec_care, pin_in,
    output vec_addr, pin_out, pin_oe, Busy, Done, Pass, Fail_idx, Fail_pins
  );

  modport master (
    output Start, vec_count, dir_mask, vec_drive, vec_expect, vec_care, pin_in,
    input  vec_addr, pin_out, pin_oe, Busy, Done, Pass, Fail_idx, Fail_pins
  );
endinterface

// File: rtl/chip_vector_tester_pin_sync.sv
// Two-flop synchroniser for the asynchronous pin readback bus.
module pin_sync #(
  parameter int unsigned WIDTH = 14
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
endmodule

// File: rtl/chip_vector_tester.sv
// Steps through an external vector ROM, drives/samples DUT pins and reports the first mismatch.
module chip_vector_tester
  import chip_tester_pkg::*;
#(
  parameter int unsigned NUM_PINS      = 14,
  parameter int unsigned NUM_VEC       = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STOP_ON_FAIL  = 1,
  localparam int unsigned VEC_AW       = vec_aw(NUM_VEC)
) (
  input logic                   Clk,
  input logic                   Reset,
  chip_vector_tester_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_e              r_state;
  logic [VEC_AW-1:0]   r_idx;
  logic [VEC_AW-1:0]   r_last;
  logic [VEC_AW-1:0]   r_vec_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_PINS-1:0] r_pin_out;
  logic [NUM_PINS-1:0] r_pin_oe;
  logic [NUM_PINS-1:0] r_expect;
  logic [NUM_PINS-1:0] r_care;
  logic                r_fail;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [VEC_AW-1:0]   r_fail_idx;
  logic [NUM_PINS-1:0] r_fail_pins;

  logic [NUM_PINS-1:0] w_sync_in;
  logic [NUM_PINS-1:0] w_mism;
  logic [VEC_AW:0]     w_count;

  pin_sync #(
    .WIDTH (NUM_PINS)
  ) u_pin_sync (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_async (bus.pin_in),
    .o_sync  (w_sync_in)
  );

  assign w_count = (bus.vec_count > (VEC_AW + 1)'(NUM_VEC)) ? (VEC_AW + 1)'(NUM_VEC)
                                                            : bus.vec_count;
  // Driven pins are excluded so bus contention never reads as a failure.
  assign w_mism  = (w_sync_in ^ r_expect) & r_care & ~bus.dir_mask;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_last      <= '0;
      r_vec_addr  <= '0;
      r_cnt       <= '0;
      r_pin_out   <= '0;
      r_pin_oe    <= '0;
      r_expect    <= '0;
      r_care      <= '0;
      r_fail      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_pins <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_pins <= '0;
            r_idx       <= '0;
            r_vec_addr  <= '0;
            r_last      <= VEC_AW'(w_count - 1'b1);
            r_busy      <= 1'b1;
            r_state     <= (w_count == '0) ? DONE : FETCH;
          end
        end
        FETCH: r_state <= DRIVE;
        DRIVE: begin
          r_pin_out <= bus.vec_drive & bus.dir_mask;
          r_pin_oe  <= bus.dir_mask;
          r_expect  <= bus.vec_expect & bus.vec_care;
          r_care    <= bus.vec_care;
          r_cnt     <= CNT_W'(SETTLE_CYCLES - 1);
          r_state   <= SETTLE;
        end
        SETTLE: begin
          if (r_cnt == '0) r_state <= SAMPLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        SAMPLE: begin
          if ((w_mism != '0) && !r_fail) begin
            r_fail      <= 1'b1;
            r_fail_idx  <= r_idx;
            r_fail_pins <= w_mism;
          end
          // Termination is decided before the increment, so idx never wraps.
          if (((w_mism != '0) && (STOP_ON_FAIL != 0)) || (r_idx == r_last)) begin
            r_state <= DONE;
          end else begin
            r_idx      <= r_idx + 1'b1;
            r_vec_addr <= r_idx + 1'b1;
            r_state    <= FETCH;
          end
        end
        DONE: begin
          r_done   <= 1'b1;
          r_pass   <= ~r_fail;
          r_busy   <= 1'b0;
          r_pin_oe <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.vec_addr  = r_vec_addr;
  assign bus.pin_out   = r_pin_out;
  assign bus.pin_oe    = r_pin_oe;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Pass      = r_pass;
  assign bus.Fail_idx  = r_fail_idx;
  assign bus.Fail_pins = r_fail_pins;
endmodule
